// File: rtl/i2c_cfg_pkg.sv
// Shared types and constants for the I2C configuration sequencer.
//   state_t     : sequencer FSM states
//   rom_entry_t : one configuration word {reg_addr, data}
package i2c_cfg_pkg;

  localparam int unsigned DEFAULT_NUM_REGS = 10;
  localparam int unsigned IDX_W            = 5;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT_BUSY,
    WAIT_DONE,
    GAP,
    DONE,
    FAIL
  } state_t;

  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] data;
  } rom_entry_t;

endpackage

// File: rtl/i2c_config_rom.sv
// Combinational table of codec initialisation words.
//   index_i : entry number (0..31)
//   entry_o : {reg_addr, data} for that entry, zero beyond the table
module i2c_config_rom
  import i2c_cfg_pkg::*;
(
  input  logic [IDX_W-1:0] index_i,
  output rom_entry_t       entry_o
);

  // Audio codec bring-up: reset, power, format, rate, line/hp levels, path, activate
  always_comb begin
    entry_o = '0;
    case (index_i)
      5'd0:    entry_o = '{reg_addr: 8'h1E, data: 8'h00};
      5'd1:    entry_o = '{reg_addr: 8'h0C, data: 8'h00};
      5'd2:    entry_o = '{reg_addr: 8'h0E, data: 8'h42};
      5'd3:    entry_o = '{reg_addr: 8'h10, data: 8'h00};
      5'd4:    entry_o = '{reg_addr: 8'h00, data: 8'h17};
      5'd5:    entry_o = '{reg_addr: 8'h02, data: 8'h17};
      5'd6:    entry_o = '{reg_addr: 8'h04, data: 8'h79};
      5'd7:    entry_o = '{reg_addr: 8'h06, data: 8'h79};
      5'd8:    entry_o = '{reg_addr: 8'h08, data: 8'h12};
      5'd9:    entry_o = '{reg_addr: 8'h12, data: 8'h01};
      default: entry_o = '0;
    endcase
  end

endmodule

// File: rtl/i2c_config_sequencer.sv
// Walks the configuration ROM and issues one I2C register write per entry,
// retrying failed writes and aborting on retry exhaustion or timeout.
//   clk, reset            : clock, asynchronous active-high reset
//   start                 : begin a sequence (honoured in IDLE/DONE/FAIL only)
//   busy, done, fail      : sequence status
//   index, retries        : current entry and retries used on it
//   slav_addr, read_not_write, reg_addr, write_data,
//   write_valid/write_ready, i2c_error : write request to the I2C master
// MAX_RETRIES must fit the 2-bit retries port; NUM_REGS must be 1..32.
module i2c_config_sequencer
  import i2c_cfg_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR     = 7'h1A,
  parameter int unsigned NUM_REGS       = DEFAULT_NUM_REGS,
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [IDX_W-1:0] index,
  output logic [1:0]       retries,
  output logic [6:0]       slav_addr,
  output logic             read_not_write,
  output logic [7:0]       reg_addr,
  output logic [7:0]       write_data,
  output logic             write_valid,
  input  logic             write_ready,
  input  logic             i2c_error
);

  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REGS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRIES);
  localparam bit               SKIP_GAP  = (GAP_CYCLES == 0);

  state_t           state_q;
  logic [IDX_W-1:0] index_q;
  logic [1:0]       retries_q;
  logic             busy_q;
  logic             done_q;
  logic             fail_q;
  logic             valid_q;
  logic [6:0]       slav_q;
  logic [7:0]       reg_addr_q;
  logic [7:0]       data_q;
  logic [TMO_W-1:0] tmo_q;
  logic [GAP_W-1:0] gap_q;
  rom_entry_t       rom_entry;

  i2c_config_rom u_rom (
    .index_i (index_q),
    .entry_o (rom_entry)
  );

  // Sequencer FSM; status outputs are updated on the same edge as the state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      index_q    <= '0;
      retries_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      valid_q    <= 1'b0;
      slav_q     <= '0;
      reg_addr_q <= '0;
      data_q     <= '0;
      tmo_q      <= '0;
      gap_q      <= '0;
    end else begin
      case (state_q)
        IDLE, DONE, FAIL: begin
          if (start) begin
            state_q   <= LOAD;
            index_q   <= '0;
            retries_q <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
          end
        end

        LOAD: begin
          reg_addr_q <= rom_entry.reg_addr;
          data_q     <= rom_entry.data;
          slav_q     <= SLAVE_ADDR;
          valid_q    <= 1'b1;
          state_q    <= SEND;
        end

        // valid_q is always high here, so ready alone completes the handshake
        SEND: begin
          if (write_ready) begin
            valid_q <= 1'b0;
            tmo_q   <= '0;
            state_q <= WAIT_BUSY;
          end
        end

        // Timeout budget is shared across WAIT_BUSY and WAIT_DONE
        WAIT_BUSY: begin
          if (tmo_q == TMO_LAST) begin
            state_q <= FAIL;
            busy_q  <= 1'b0;
            fail_q  <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
            if (!write_ready) begin
              state_q <= WAIT_DONE;
            end
          end
        end

        // Completion wins over a timeout landing on the same cycle
        WAIT_DONE: begin
          if (write_ready) begin
            if (!i2c_error) begin
              if (index_q == LAST_IDX) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                index_q   <= index_q + 1'b1;
                retries_q <= '0;
                gap_q     <= '0;
                state_q   <= SKIP_GAP ? LOAD : GAP;
              end
            end else if (retries_q < RETRY_MAX) begin
              retries_q <= retries_q + 2'd1;
              gap_q     <= '0;
              state_q   <= SKIP_GAP ? LOAD : GAP;
            end else begin
              state_q <= FAIL;
              busy_q  <= 1'b0;
              fail_q  <= 1'b1;
            end
          end else if (tmo_q == TMO_LAST) begin
            state_q <= FAIL;
            busy_q  <= 1'b0;
            fail_q  <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end

        GAP: begin
          if (gap_q == GAP_LAST) begin
            state_q <= LOAD;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign fail           = fail_q;
  assign index          = index_q;
  assign retries        = retries_q;
  assign slav_addr      = slav_q;
  assign read_not_write = 1'b0;
  assign reg_addr       = reg_addr_q;
  assign write_data     = data_q;
  assign write_valid    = valid_q;

endmodule

// File: doc/i2c_config_sequencer.md
I2C_CONFIG_SEQUENCER -- requirements
Module: i2c_config_sequencer

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h1A, 7-bit target device address for every write.
REQ-002 SHALL have parameter NUM_REGS, default 10, number of ROM entries sent per sequence (1..32).
REQ-003 SHALL have parameter GAP_CYCLES, default 4, idle cycles between completed transaction and next request.
REQ-004 SHALL have parameter MAX_RETRIES, default 3, resends allowed per entry after an error.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 64, maximum cycles to wait for transaction completion.
REQ-006 SHALL have ports: clk input 1, single clock (same I2C-rate clock as the master); reset input 1, asynchronous, active-high.
REQ-007 SHALL have ports: start input 1, begin a sequence; busy output 1, sequence in progress; done output 1, all entries acknowledged; fail output 1, sequence aborted.
REQ-008 SHALL have ports: index output 5, current ROM entry; retries output 2, retries used on current entry.
REQ-009 SHALL have master-facing ports: slav_addr output 7; read_not_write output 1; reg_addr output 8; write_data output 8; write_valid output 1; write_ready input 1; i2c_error input 1.

Function
REQ-010 SHALL implement states IDLE, LOAD, SEND, WAIT_BUSY, WAIT_DONE, GAP, DONE, FAIL.
REQ-011 IDLE/DONE/FAIL: start=1 SHALL go to LOAD with index=0, retries=0, done=0, fail=0; start in any other state SHALL be ignored.
REQ-012 LOAD SHALL register the ROM entry at index ({reg_addr, write_data}) in one cycle, then go to SEND.
REQ-013 SEND SHALL hold write_valid=1 with stable slav_addr=SLAVE_ADDR, read_not_write=0, reg_addr, write_data until write_valid&&write_ready, then go to WAIT_BUSY.
REQ-014 write_valid SHALL be 0 in every state except SEND; it SHALL drop the cycle after the handshake.
REQ-015 WAIT_BUSY SHALL wait for write_ready=0, then go to WAIT_DONE.
REQ-016 WAIT_DONE SHALL wait for write_ready=1 and sample i2c_error in that same cycle; the error is valid for that single cycle only.
REQ-017 On completion with i2c_error=0: last entry (index==NUM_REGS-1) SHALL go to DONE; otherwise index+1, retries=0, go to GAP.
REQ-018 On completion with i2c_error=1: retries<MAX_RETRIES SHALL increment retries and go to GAP with same index; otherwise go to FAIL.
REQ-019 GAP SHALL last exactly GAP_CYCLES cycles, then go to LOAD.
REQ-020 A timeout counter SHALL run in WAIT_BUSY and WAIT_DONE; reaching TIMEOUT_CYCLES SHALL go to FAIL.
REQ-021 busy SHALL be 1 in LOAD..GAP; done SHALL be 1 only in DONE; fail SHALL be 1 only in FAIL; index SHALL hold the failing entry in FAIL.
REQ-022 Counters SHALL saturate/clear explicitly; no wrap of index past NUM_REGS-1.

Reset
REQ-023 reset SHALL asynchronously force IDLE, index=0, retries=0, counters=0, write_valid=0, busy=0, done=0, fail=0, data outputs 0.
REQ-024 Reset mid-transaction SHALL take effect immediately without completing the handshake.

Structure
REQ-025 Package i2c_cfg_pkg SHALL hold the state enum, a 16-bit rom entry typedef {reg_addr, data}, and default NUM_REGS.
REQ-026 Sub-module i2c_config_rom SHALL provide a combinational index->entry table (codec init words); sequencer instantiates it once.

Verification
REQ-027 Bench SHALL model the master handshake: ready high when idle, low for 30 cycles after acceptance, i2c_error settable per transaction.
REQ-028 Clean run: NUM_REGS=3, start pulse -> three handshakes with ROM words 0,1,2 in order, done=1, fail=0, gaps of 4 cycles.
REQ-029 Single error: error on entry 1 first attempt -> entry 1 resent once, retries=1 then cleared, done=1.
REQ-030 Persistent error: error on entry 2 every attempt -> 4 sends of entry 2, then fail=1, index=2.
REQ-031 Timeout: write_ready held low after handshake -> fail=1 after 64 cycles, write_valid=0.
REQ-032 Reset at WAIT_DONE and start during busy -> immediate IDLE with all outputs 0; start while busy produces no extra handshake.
